cnu_lut_iter_sched: RTL and testbench
=====================================

Name: cnu_lut_iter_sched

Overview:
Iteration scheduler for the decomposed-LUT check-node unit (CNU) in the IB-LDPC decoder. It drives the control inputs of the CNU write/update handshake: initial-load enable, read-finish and iteration-update. It sequences each decode through initial LUT load, per-iteration CNU read sweeps and iteration advance, ending on max iteration or early termination. It sits between the top-level decode FSM and the CNU handshake/LUT memory.

Parameters:
MAX_ITER, 10, maximum decoding iterations per codeword (>=1)
ITER_W, 4, iteration counter width; must hold MAX_ITER
LOAD_LEN, 4, cycles of initial LUT load (>=1)
RD_LEN, 8, cycles of one CNU read sweep (>=1)
WR_TIMEOUT, 16, maximum cycles waiting for the cnu_wr toggle (>=2)

Ports:
read_clk  in  1  decoder clock
rstn  in  1  asynchronous active-low reset
decode_start_i  in  1  start a decode; level sampled, honoured only in IDLE
abort_i  in  1  synchronous abort
early_term_i  in  1  syndrome-zero indication
cnu_wr_i  in  1  cnu_wr_o returned from the CNU handshake block
cnu_init_load_en_o  out  1  initial-load phase enable
cnu_rd_en_o  out  1  CNU LUT read sweep enable
cnu_rd_finish_o  out  1  read sweep finished; pipe-load request
iter_update_o  out  1  one-cycle iteration-advance pulse
iter_cnt_o  out  ITER_W  completed iterations
busy_o  out  1  high in every state except IDLE
decode_done_o  out  1  one-cycle completion pulse
error_o  out  1  write-handshake timeout, sticky

Behaviour:
- Clock and reset: single clock read_clk, asynchronous active-low reset rstn. All registers reset to 0 and the state to IDLE. All outputs are 0 at reset.
- States: IDLE, INIT_LOAD, CNU_RD, RD_FIN, ITER_UPD, DONE, ERR. All outputs are registered or decoded from the state register only. No combinational input-to-output paths.
- IDLE:
  - Clears the early-term latch, the counters and iter_cnt_o.
  - decode_start_i=1 at an edge: enter INIT_LOAD.
- INIT_LOAD:
  - cnu_init_load_en_o=1 for exactly LOAD_LEN cycles.
  - Then enter CNU_RD.
- CNU_RD:
  - cnu_rd_en_o=1 for exactly RD_LEN cycles.
  - On the last cycle, snapshot cnu_wr_i into wr_snap, then enter RD_FIN.
- RD_FIN:
  - cnu_rd_finish_o=1 while in this state. The wait counter starts at 0 on entry.
  - cnu_wr_i != wr_snap sampled at an edge: enter ITER_UPD.
  - Else, when the wait counter reaches WR_TIMEOUT-1: enter ERR.
  - If the toggle and the timeout hit in the same cycle, the toggle wins.
- ITER_UPD:
  - iter_update_o=1 for one cycle; iter_cnt_o increments at the exit edge.
  - Next state is DONE if the early-term latch is set, early_term_i is high this cycle, or iter_cnt_o+1==MAX_ITER. Otherwise next state is CNU_RD; the initial load is not repeated.
- DONE:
  - decode_done_o=1 for one cycle, then IDLE.
  - iter_cnt_o holds its value through DONE and the following IDLE cycle. It clears on the next IDLE edge.
- ERR:
  - error_o=1 (sticky); all other control outputs are 0.
  - Leaves only via abort_i to IDLE, which clears error_o.
- early_term_i:
  - Latched, sticky, in any busy state.
  - Does not truncate a CNU_RD or RD_FIN in progress; takes effect at the next ITER_UPD.
- abort_i:
  - From any state, enter IDLE at the next edge; all enables are 0 from that edge.
  - Has priority over every other transition.
- decode_start_i while busy: ignored.
- Mid-operation rstn assertion: outputs go to 0 immediately (asynchronous), with no pulse generated.
- Counter widths: $clog2 of the respective length, minimum 1 bit. No counter wraps; every counter is cleared on each state entry.

Decomposition:
- Shared package (decoder control package):
  - State encoding enum: IDLE=0, INIT_LOAD=1, CNU_RD=2, RD_FIN=3, ITER_UPD=4, DONE=5, ERR=6.
  - Default MAX_ITER/LOAD_LEN/RD_LEN/WR_TIMEOUT constants.
  - Width helper for the counters.
- One sub-module is natural: cnu_phase_cnt, a loadable down-counter with a terminal-count flag. It is instantiated for the load length, read length and timeout, or shared with a muxed load value.

Test Plan:
- Reset: hold rstn=0 then release → all outputs 0, iter_cnt_o=0, busy_o=0. No pulse on the release edge.
- Nominal run (MAX_ITER=3, LOAD_LEN=4, RD_LEN=8); start at edge E0; bench toggles cnu_wr_i 2 cycles after each cnu_rd_finish_o rise → expect:
  - cnu_init_load_en_o for 4 cycles;
  - three rounds of cnu_rd_en_o for 8 cycles each, then cnu_rd_finish_o for 2 cycles, then iter_update_o;
  - decode_done_o once, with iter_cnt_o=3.
- Early termination: early_term_i pulsed for 1 cycle during the second CNU_RD → that sweep completes, iter_update_o pulses, DONE follows with iter_cnt_o=2. No third cnu_rd_en_o.
- Timeout (WR_TIMEOUT=16): cnu_wr_i never toggles → cnu_rd_finish_o high for 16 cycles, then error_o=1 and all enables 0. decode_start_i is then ignored; abort_i returns to IDLE with error_o=0.
- Toggle on the final timeout cycle: cnu_wr_i toggles at wait count 15 → ITER_UPD, error_o stays 0.
- Abort and reset mid-run: abort_i in cycle 3 of CNU_RD → IDLE next edge, cnu_rd_en_o=0. A new start then yields a full 4-cycle init load. rstn pulsed low during RD_FIN → outputs 0 immediately, no decode_done_o.

Source files
------------

// File: rtl/cnu_lut_iter_sched_pkg.sv
// Shared decoder-control definitions for the CNU iteration scheduler:
// state encoding, default sizing, counter width helper and the
// state-to-control-output decode.
package cnu_lut_iter_sched_pkg;

  localparam int DEF_MAX_ITER   = 10;
  localparam int DEF_ITER_W     = 4;
  localparam int DEF_LOAD_LEN   = 4;
  localparam int DEF_RD_LEN     = 8;
  localparam int DEF_WR_TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT_LOAD = 3'd1,
    CNU_RD    = 3'd2,
    RD_FIN    = 3'd3,
    ITER_UPD  = 3'd4,
    DONE      = 3'd5,
    ERR       = 3'd6
  } state_e;

  // Control outputs driven towards the CNU handshake and the decode FSM.
  typedef struct packed {
    logic init_load_en;
    logic rd_en;
    logic rd_finish;
    logic iter_update;
    logic decode_done;
    logic busy;
    logic error;
  } ctl_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Every control output is a pure function of the state register.
  function automatic ctl_t ctl_of(input state_e s);
    ctl_t c;
    c      = '0;
    c.busy = (s != IDLE);
    case (s)
      INIT_LOAD: c.init_load_en = 1'b1;
      CNU_RD:    c.rd_en        = 1'b1;
      RD_FIN:    c.rd_finish    = 1'b1;
      ITER_UPD:  c.iter_update  = 1'b1;
      DONE:      c.decode_done  = 1'b1;
      ERR:       c.error        = 1'b1;
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cnu_lut_iter_sched_if.sv
// Control bundle between the decode FSM / CNU handshake (master) and the
// iteration scheduler (slave).
interface cnu_lut_iter_sched_if #(
  parameter int ITER_W = 4
);
  logic              decode_start_i;
  logic              abort_i;
  logic              early_term_i;
  logic              cnu_wr_i;
  logic              cnu_init_load_en_o;
  logic              cnu_rd_en_o;
  logic              cnu_rd_finish_o;
  logic              iter_update_o;
  logic [ITER_W-1:0] iter_cnt_o;
  logic              busy_o;
  logic              decode_done_o;
  logic              error_o;

  modport slave (
    input  decode_start_i, abort_i, early_term_i, cnu_wr_i,
    output cnu_init_load_en_o, cnu_rd_en_o, cnu_rd_finish_o, iter_update_o,
           iter_cnt_o, busy_o, decode_done_o, error_o
  );

  modport master (
    output decode_start_i, abort_i, early_term_i, cnu_wr_i,
    input  cnu_init_load_en_o, cnu_rd_en_o, cnu_rd_finish_o, iter_update_o,
           iter_cnt_o, busy_o, decode_done_o, error_o
  );
endinterface

// File: rtl/cnu_lut_iter_sched_phase_cnt.sv
// Loadable saturating down-counter; tc flags the last cycle of a phase.
module cnu_phase_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;

  // Load on phase entry, otherwise count down and hold at zero.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/cnu_lut_iter_sched.sv
// Iteration scheduler for the decomposed-LUT CNU: initial LUT load, per
// iteration read sweep, write-handshake wait and iteration advance, ending
// on max iteration, early termination, timeout (sticky error) or abort.
module cnu_lut_iter_sched
  import cnu_lut_iter_sched_pkg::*;
#(
  parameter int MAX_ITER   = DEF_MAX_ITER,
  parameter int ITER_W     = DEF_ITER_W,
  parameter int LOAD_LEN   = DEF_LOAD_LEN,
  parameter int RD_LEN     = DEF_RD_LEN,
  parameter int WR_TIMEOUT = DEF_WR_TIMEOUT
) (
  input  logic                 read_clk,
  input  logic                 rstn,
  cnu_lut_iter_sched_if.slave  bus
);
  localparam int CNT_W = max3(cnt_w(LOAD_LEN), cnt_w(RD_LEN), cnt_w(WR_TIMEOUT));
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_LEN - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_LEN - 1);
  localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_TIMEOUT - 1);

  state_e            state;
  logic [ITER_W-1:0] iter_cnt;
  logic              et_latch;
  logic              wr_snap;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_tc;
  logic              wr_toggled;
  logic              last_iter;
  ctl_t              ctl;

  // One counter serves all timed phases; it is reloaded on each phase entry.
  cnu_phase_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk      (read_clk),
    .rst_n    (rstn),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  assign wr_toggled = (bus.cnu_wr_i != wr_snap);
  assign last_iter  = et_latch | bus.early_term_i
                    | ((int'(iter_cnt) + 1) == MAX_ITER);

  // Select the phase length to load when the next timed phase is entered.
  // NOTE: defaults assigned first keep this block free of inferred latches.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      IDLE:      begin cnt_load = 1'b1;   cnt_val = LOAD_LAST; end
      INIT_LOAD: begin cnt_load = cnt_tc; cnt_val = RD_LAST;   end
      CNU_RD:    begin cnt_load = cnt_tc; cnt_val = WR_LAST;   end
      ITER_UPD:  begin cnt_load = 1'b1;   cnt_val = RD_LAST;   end
      default:   ;
    endcase
  end

  // Scheduler FSM; abort overrides every other transition.
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      iter_cnt <= '0;
      et_latch <= 1'b0;
      wr_snap  <= 1'b0;
    end else begin
      if (state != IDLE && bus.early_term_i) et_latch <= 1'b1;
      if (bus.abort_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            et_latch <= 1'b0;
            iter_cnt <= '0;
            if (bus.decode_start_i) state <= INIT_LOAD;
          end
          INIT_LOAD: if (cnt_tc) state <= CNU_RD;
          CNU_RD: if (cnt_tc) begin
            wr_snap <= bus.cnu_wr_i;
            state   <= RD_FIN;
          end
          RD_FIN: begin
            if (wr_toggled)  state <= ITER_UPD;
            else if (cnt_tc) state <= ERR;
          end
          ITER_UPD: begin
            iter_cnt <= iter_cnt + ITER_W'(1);
            state    <= last_iter ? DONE : CNU_RD;
          end
          DONE:    state <= IDLE;
          ERR:     state <= ERR;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign ctl                    = ctl_of(state);
  assign bus.cnu_init_load_en_o = ctl.init_load_en;
  assign bus.cnu_rd_en_o        = ctl.rd_en;
  assign bus.cnu_rd_finish_o    = ctl.rd_finish;
  assign bus.iter_update_o      = ctl.iter_update;
  assign bus.decode_done_o      = ctl.decode_done;
  assign bus.busy_o             = ctl.busy;
  assign bus.error_o            = ctl.error;
  assign bus.iter_cnt_o         = iter_cnt;
endmodule

// File: tb/tb_cnu_lut_iter_sched.sv
// Scoreboard bench for cnu_lut_iter_sched: a phase-level model predicts the
// sequence of output phases (kind, length, iteration count) per decode and a
// monitor compresses the observed outputs into the same phase records.
module tb_cnu_lut_iter_sched;
  localparam int MAX_ITER = 3, LOAD_LEN = 4, RD_LEN = 8, WR_TIMEOUT = 16;
  localparam int K_I = 0, K_L = 1, K_R = 2, K_F = 3, K_U = 4, K_D = 5,
                 K_E = 6, K_X = 7, K_PD = 8, K_CLR = 9;

  logic clk = 1'b0;
  logic rstn;
  int   tests = 0, fails = 0;
  logic [31:0] exp_q[$];
  int   dly_q[$];
  int   sweeps = 0;
  int   et_target = -1;

  cnu_lut_iter_sched_if #(.ITER_W(4)) bus();

  cnu_lut_iter_sched #(
    .MAX_ITER(MAX_ITER), .ITER_W(4), .LOAD_LEN(LOAD_LEN),
    .RD_LEN(RD_LEN), .WR_TIMEOUT(WR_TIMEOUT)
  ) dut (
    .read_clk (clk),
    .rstn     (rstn),
    .bus      (bus)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] tok(input int k, input int len, input int val);
    return {8'(k), 16'(len), 8'(val)};
  endfunction

  function automatic logic [10:0] all_outs();
    return {bus.cnu_init_load_en_o, bus.cnu_rd_en_o, bus.cnu_rd_finish_o,
            bus.iter_update_o, bus.decode_done_o, bus.busy_o, bus.error_o,
            bus.iter_cnt_o};
  endfunction

  // Map the output vector to a phase kind; illegal combinations become K_X.
  function automatic int classify();
    int n;
    n = int'(bus.cnu_init_load_en_o) + int'(bus.cnu_rd_en_o) + int'(bus.cnu_rd_finish_o)
      + int'(bus.iter_update_o) + int'(bus.decode_done_o) + int'(bus.error_o);
    if (n == 0) return bus.busy_o ? K_X : K_I;
    if (n > 1 || !bus.busy_o) return K_X;
    if (bus.cnu_init_load_en_o) return K_L;
    if (bus.cnu_rd_en_o)        return K_R;
    if (bus.cnu_rd_finish_o)    return K_F;
    if (bus.iter_update_o)      return K_U;
    if (bus.decode_done_o)      return K_D;
    return K_E;
  endfunction

  task automatic emit(input int k, input int len, input int val);
    logic [31:0] got;
    got = tok(k, len, val);
    if (exp_q.size() == 0) check("unexpected_event", got, 32'hFFFF_FFFF);
    else                   check("event", got, exp_q.pop_front());
  endtask

  // Monitor: emits a record at the end of each phase run (entry for ERR).
  initial begin
    int cur, run, v0, s, post;
    cur = K_I; run = 0; v0 = 0; post = 0;
    forever begin
      @(negedge clk);
      s = classify();
      if (post != 0) begin
        emit(K_CLR, 0, int'(bus.iter_cnt_o));
        post = 0;
      end
      if (s != cur) begin
        if (cur >= K_L && cur <= K_D) emit(cur, run, v0);
        if (cur == K_D) begin
          emit(K_PD, 0, int'(bus.iter_cnt_o));
          post = 1;
        end
        cur = s; run = 1; v0 = int'(bus.iter_cnt_o);
        if (s == K_E) emit(K_E, 0, 0);
        if (s == K_X) emit(K_X, 0, v0);
      end else begin
        run++;
      end
    end
  end

  // CNU handshake stand-in: toggles cnu_wr_i so read-finish lasts d cycles.
  initial begin
    logic prev;
    int d;
    prev = 1'b0;
    bus.cnu_wr_i = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.cnu_rd_finish_o && !prev) begin
        d = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
        if (d > 0) begin
          for (int k = 1; k < d; k++) @(negedge clk);
          if (bus.cnu_rd_finish_o) bus.cnu_wr_i = ~bus.cnu_wr_i;
        end
      end
      prev = bus.cnu_rd_finish_o;
    end
  end

  // Early-termination source: one-cycle pulse inside the targeted sweep.
  initial begin
    logic prev;
    int r;
    prev = 1'b0;
    bus.early_term_i = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.cnu_rd_en_o && !prev) begin
        sweeps++;
        if (sweeps == et_target) begin
          r = $urandom_range(0, 6);
          repeat (r) @(negedge clk);
          bus.early_term_i = 1'b1;
          @(negedge clk);
          bus.early_term_i = 1'b0;
        end
      end
      prev = bus.cnu_rd_en_o;
    end
  end

  // Reference model: expected phase records for one decode.
  task automatic build_exp(input int d0, input int d1, input int d2, input int et,
                           output bit err);
    int d[3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    err = 1'b0;
    exp_q.push_back(tok(K_L, LOAD_LEN, 0));
    for (int it = 0; it < MAX_ITER; it++) begin
      exp_q.push_back(tok(K_R, RD_LEN, it));
      if (d[it] == 0) begin
        exp_q.push_back(tok(K_F, WR_TIMEOUT, it));
        exp_q.push_back(tok(K_E, 0, 0));
        err = 1'b1;
        return;
      end
      exp_q.push_back(tok(K_F, d[it], it));
      exp_q.push_back(tok(K_U, 1, it));
      if (it == et || it + 1 == MAX_ITER) begin
        exp_q.push_back(tok(K_D, 1, it + 1));
        exp_q.push_back(tok(K_PD, 0, it + 1));
        exp_q.push_back(tok(K_CLR, 0, 0));
        return;
      end
    end
  endtask

  task automatic start_pulse();
    bus.decode_start_i = 1'b1;
    @(negedge clk);
    bus.decode_start_i = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic prep(input int et);
    exp_q.delete();
    dly_q.delete();
    sweeps = 0;
    et_target = (et < 0) ? -1 : et + 1;
  endtask

  task automatic run_decode(input int d0, input int d1, input int d2, input int et);
    bit err;
    prep(et);
    build_exp(d0, d1, d2, et, err);
    dly_q.push_back(d0); dly_q.push_back(d1); dly_q.push_back(d2);
    start_pulse();
    drain("decode_drain");
    if (err) begin
      bus.decode_start_i = 1'b1;
      repeat (3) @(negedge clk);
      bus.decode_start_i = 1'b0;
      check("err_sticky_busy", {bus.error_o, bus.busy_o, bus.cnu_init_load_en_o}, 3'b110);
      bus.abort_i = 1'b1;
      @(negedge clk);
      bus.abort_i = 1'b0;
      check("err_cleared_by_abort", {bus.error_o, bus.busy_o}, 2'b00);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int d0, d1, d2, et;
    rstn = 1'b0;
    bus.decode_start_i = 1'b0;
    bus.abort_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    rstn = 1'b1;
    @(negedge clk);
    check("release_no_pulse", all_outs(), 0);
    repeat (2) @(negedge clk);
    check("release_idle", all_outs(), 0);

    run_decode(2, 2, 2, -1);      // nominal three iterations
    run_decode(2, 2, 2, 1);       // early termination in second sweep
    run_decode(0, 2, 2, -1);      // write handshake never toggles
    run_decode(16, 16, 16, -1);   // toggle on the last timeout cycle

    // Abort in cycle 3 of the first read sweep, then a full decode.
    prep(-1);
    exp_q.push_back(tok(K_L, LOAD_LEN, 0));
    exp_q.push_back(tok(K_R, 3, 0));
    start_pulse();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cnu_rd_en_o) break;
    end
    check("abort_rd_seen", bus.cnu_rd_en_o, 1'b1);
    @(negedge clk);
    @(negedge clk);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    check("abort_to_idle", {bus.cnu_rd_en_o, bus.busy_o}, 2'b00);
    drain("abort_drain");
    repeat (2) @(negedge clk);
    run_decode(3, 1, 5, -1);

    // Asynchronous reset during the write-handshake wait.
    prep(-1);
    exp_q.push_back(tok(K_L, LOAD_LEN, 0));
    exp_q.push_back(tok(K_R, RD_LEN, 0));
    exp_q.push_back(tok(K_F, 4, 0));
    dly_q.push_back(10);
    start_pulse();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cnu_rd_finish_o) break;
    end
    check("rst_fin_seen", bus.cnu_rd_finish_o, 1'b1);
    repeat (3) @(negedge clk);
    #1 rstn = 1'b0;
    #1 check("async_reset_outputs", all_outs(), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    drain("reset_drain");
    repeat (20) @(negedge clk);
    check("post_reset_idle", all_outs(), 0);

    // Randomized decodes: random handshake delays, timeouts and early stops.
    for (int n = 0; n < 10; n++) begin
      d0 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 16));
      d1 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 16));
      d2 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 16));
      et = int'($urandom_range(0, 3)) - 1;
      run_decode(d0, d1, d2, et);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
